// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types, default sizes and width helpers for the round-robin mux arbiter.
package mux_arb_pkg;
    typedef enum logic {IDLE, GRANT} arb_state_e;
    localparam int DEF_M        = 64;
    localparam int DEF_ADDR     = 6;
    localparam int DEF_MAX_HOLD = 16;
    function automatic int safe_clog2(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
    // Keeps the hold counter at least one bit wide when MAX_HOLD=0 (unlimited hold).
    function automatic int hold_w(input int max_hold);
        return safe_clog2(max_hold + 1);
    endfunction
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: circular first-set search from base, with one optional index masked out.
module arb_rr_pick
    import mux_arb_pkg::*;
#(
    parameter int M    = DEF_M,
    parameter int ADDR = DEF_ADDR
) (
    input  logic [M-1:0]    req,
    input  logic [ADDR-1:0] base,
    input  logic [ADDR-1:0] mask_idx,
    input  logic            mask_en,
    output logic            hit,
    output logic [ADDR-1:0] idx
);
    logic [M-1:0]    w_req;
    logic [M-1:0]    w_rot;
    logic [ADDR-1:0] w_off;
    assign w_req = req & ~({{(M-1){1'b0}}, mask_en} << mask_idx);
    // Bit k of w_rot is requester (base+k) mod M.
    assign w_rot = M'({w_req, w_req} >> base);
    always_comb begin
        w_off = '0;
        for (int k = M - 1; k >= 0; k--)
            if (w_rot[k]) w_off = k[ADDR-1:0];
    end
    assign hit = |w_req;
    assign idx = base + w_off;
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter driving the select of a shared M:1 mux,
// with grant hold capped at MAX_HOLD consecutive cycles per owner.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int M        = DEF_M,
    parameter int ADDR     = DEF_ADDR,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [M-1:0]    req_i,
    output logic [M-1:0]    gnt_o,
    output logic [ADDR-1:0] sel_o,
    output logic            valid_o
);
    localparam int HW = hold_w(MAX_HOLD);
    arb_state_e      r_state, w_state;
    logic [ADDR-1:0] r_ptr, w_ptr, r_sel, w_sel;
    logic [HW-1:0]   r_hold, w_hold;
    logic [M-1:0]    r_gnt, w_gnt;
    logic            w_mask, w_own, w_exp, w_hit;
    logic [ADDR-1:0] w_base, w_idx;
    logic [M-1:0]    w_onehot;
    // While granting, the search starts just past the owner with the owner masked.
    assign w_mask   = r_state == GRANT;
    assign w_base   = w_mask ? r_sel + ADDR'(1) : r_ptr;
    assign w_own    = req_i[r_sel];
    assign w_exp    = (MAX_HOLD != 0) && (r_hold == HW'(MAX_HOLD - 1));
    assign w_onehot = {{(M-1){1'b0}}, 1'b1} << w_idx;
    arb_rr_pick #(.M(M), .ADDR(ADDR)) u_pick (
        .req     (req_i),
        .base    (w_base),
        .mask_idx(r_sel),
        .mask_en (w_mask),
        .hit     (w_hit),
        .idx     (w_idx)
    );
    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_sel   = r_sel;
        w_hold  = r_hold;
        w_gnt   = r_gnt;
        if (r_state == IDLE) begin
            if (w_hit) begin
                w_state = GRANT;
                w_sel   = w_idx;
                w_gnt   = w_onehot;
                w_hold  = '0;
            end
        end else if (w_own && !w_exp) begin
            w_hold = r_hold + HW'(1);
        end else begin
            w_ptr  = w_base;
            w_hold = '0;
            if (w_hit) begin
                w_sel = w_idx;
                w_gnt = w_onehot;
            end else if (!w_own) begin
                w_state = IDLE;
                w_sel   = '0;
                w_gnt   = '0;
            end
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_hold  <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_sel   <= w_sel;
            r_hold  <= w_hold;
            r_gnt   <= w_gnt;
        end
    end
    assign gnt_o   = r_gnt;
    assign sel_o   = r_sel;
    assign valid_o = r_state == GRANT;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed and random checks of mux_rr_arbiter (MAX_HOLD=4) feeding a 64:1 mux model.
module tb_mux_rr_arbiter;
    localparam int M    = 64;
    localparam int ADDR = 6;
    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [M-1:0]    req   = '0;
    logic [M-1:0]    gnt;
    logic [ADDR-1:0] sel;
    logic            valid;
    logic [ADDR-1:0] mux_in [M];
    logic [ADDR-1:0] mux_out;
    logic [M-1:0]    prev_gnt, prev_req, sticky;
    int              wait_cnt [M];
    int              checks = 0;
    int              errors = 0;
    int              ord [6] = '{2, 9, 40, 2, 9, 40};

    mux_rr_arbiter #(.M(M), .ADDR(ADDR), .MAX_HOLD(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .req_i  (req),
        .gnt_o  (gnt),
        .sel_o  (sel),
        .valid_o(valid)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < M; i++) mux_in[i] = ADDR'(i);
    assign mux_out = mux_in[sel];

    function automatic logic [M-1:0] b(input int i);
        return {{(M-1){1'b0}}, 1'b1} << i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic v);
        logic [M-1:0]    eg;
        logic [ADDR-1:0] es;
        eg = v ? b(idx) : '0;
        es = v ? ADDR'(idx) : '0;
        checks++;
        assert ({gnt, sel, valid} === {eg, es, v}) else begin
            errors++;
            $error("FAIL %s: got gnt=%h sel=%0d valid=%b, want gnt=%h sel=%0d valid=%b",
                   tag, gnt, sel, valid, eg, es, v);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Continuous invariants, mux datapath and starvation bound.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_gnt = '0;
            prev_req = '0;
            for (int i = 0; i < M; i++) wait_cnt[i] = 0;
        end else begin
            int worst;
            logic new_grant;
            checks++;
            assert ($onehot0(gnt) && gnt[sel] === valid && (valid || sel == '0)) else begin
                errors++;
                $error("FAIL invariant: gnt=%h sel=%0d valid=%b", gnt, sel, valid);
            end
            if (valid) begin
                checks++;
                assert (mux_out === sel) else begin
                    errors++;
                    $error("FAIL datapath: data_o=%0d want %0d", mux_out, sel);
                end
            end
            new_grant = valid && (gnt !== prev_gnt);
            worst = 0;
            for (int i = 0; i < M; i++) begin
                if (gnt[i] || !prev_req[i]) wait_cnt[i] = 0;
                else if (new_grant) wait_cnt[i]++;
                if (wait_cnt[i] > worst) worst = wait_cnt[i];
            end
            checks++;
            assert (worst <= M - 1) else begin
                errors++;
                $error("FAIL starvation: waited %0d grants, limit %0d", worst, M - 1);
            end
            prev_gnt = gnt;
            prev_req = req;
        end
    end

    initial begin
        // Reset and async reset mid-grant; ptr must return to 0.
        repeat (2) tick();
        chk("reset", 0, 1'b0);
        rst_n = 1'b1;
        req = b(5);
        tick();
        chk("first_grant", 5, 1'b1);
        req = '0;
        tick();
        chk("release_idle", 0, 1'b0);
        req = b(5);
        tick();
        chk("regrant", 5, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 0, 1'b0);
        tick();
        chk("in_reset", 0, 1'b0);
        rst_n = 1'b1;
        req = b(3) | b(40);
        tick();
        chk("ptr_reset", 3, 1'b1);
        req = '0;
        tick();
        chk("idle1", 0, 1'b0);
        // Fairness with back-to-back handoffs.
        do_reset();
        req = b(2) | b(9) | b(40);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("fair", ord[k], 1'b1);
            req = (b(2) | b(9) | b(40)) & ~b(ord[k]);
        end
        req = '0;
        tick();
        chk("idle2", 0, 1'b0);
        // Hold cap of 4 cycles between two persistent requesters.
        do_reset();
        req = b(7) | b(8);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("hold_cap", ((k / 4) % 2 == 1) ? 8 : 7, 1'b1);
        end
        req = '0;
        tick();
        chk("idle3", 0, 1'b0);
        // Lone owner keeps grant across hold expiry.
        do_reset();
        req = b(10);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("lone", 10, 1'b1);
        end
        req = '0;
        tick();
        chk("idle4", 0, 1'b0);
        // Wrap from 63 to 0, then on to 62.
        do_reset();
        req = b(63);
        tick();
        chk("wrap_63", 63, 1'b1);
        req = b(0) | b(62);
        tick();
        chk("wrap_0", 0, 1'b1);
        req = b(62);
        tick();
        chk("wrap_62", 62, 1'b1);
        req = '0;
        tick();
        chk("idle5", 0, 1'b0);
        // Random traffic; monitor checks datapath, one-hot and starvation.
        do_reset();
        sticky = '0;
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0)
                sticky = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            req = sticky | ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            tick();
        end
        req = '0;
        tick();
        tick();
        chk("idle_end", 0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
